// File: rtl/pmu_pkg.sv
// Shared PMU definitions: default counter geometry, index width helper and the
// counter array type consumed by the downstream quota checker.
package pmu_pkg;

   localparam int PMU_REG_WIDTH  = 32;
   localparam int PMU_N_COUNTERS = 9;

   // Index width for a bank of n counters, never narrower than one bit.
   function automatic int pmu_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef logic [PMU_REG_WIDTH-1:0] counter_array_t [PMU_N_COUNTERS];

endpackage

// File: rtl/pmu_counter_cell.sv
// One event counter with its sticky wrap-around flag.
// Priority: reset/softrst > write > increment > hold.
module pmu_counter_cell #(
   parameter int REG_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 softrst_i,
   input  logic                 inc_i,
   input  logic                 wr_i,
   input  logic [REG_WIDTH-1:0] wr_data_i,
   input  logic                 ovf_clr_i,
   output logic [REG_WIDTH-1:0] value_o,
   output logic                 ovf_o
);

   logic [REG_WIDTH-1:0] value_q, value_d;
   logic                 ovf_q, ovf_d;
   logic                 wrap;

   always_comb begin
      value_d = value_q;
      wrap    = 1'b0;
      if (wr_i) begin
         value_d = wr_data_i;
      end else if (inc_i) begin
         value_d = value_q + REG_WIDTH'(1);
         wrap    = &value_q;
      end
      // A wrap in the same cycle as a clear keeps the flag set.
      ovf_d = wrap | (ovf_q & ~ovf_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i || softrst_i) begin
         value_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         ovf_q   <= ovf_d;
      end
   end

   assign value_o = value_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/pmu_event_counters.sv
// PMU counting stage: registered event inputs feeding a bank of counter cells,
// with write-index decode and a registered, maskable overflow interrupt.
module pmu_event_counters
   import pmu_pkg::*;
#(
   parameter  int REG_WIDTH  = PMU_REG_WIDTH,
   parameter  int N_COUNTERS = PMU_N_COUNTERS,
   localparam int IDX_W      = pmu_idx_w(N_COUNTERS)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  softrst_i,
   input  logic                  en_i,
   input  logic [N_COUNTERS-1:0] events_i,
   input  logic                  wr_en_i,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [REG_WIDTH-1:0]  wr_data_i,
   input  logic [N_COUNTERS-1:0] ovf_mask_i,
   input  logic [N_COUNTERS-1:0] ovf_clr_i,
   output logic [REG_WIDTH-1:0]  counter_value_o [N_COUNTERS],
   output logic [N_COUNTERS-1:0] overflow_o,
   output logic                  intr_overflow_o
);

   logic [N_COUNTERS-1:0] ev_q, ev_d;
   logic [N_COUNTERS-1:0] wr_sel;
   logic [N_COUNTERS-1:0] ovf;
   logic                  intr_q, intr_d;

   assign ev_d   = en_i ? events_i : '0;
   // Interrupt looks at the registered flags, so it trails them by a cycle.
   assign intr_d = |(ovf & ovf_mask_i);

   always_ff @(posedge clk_i) begin
      if (!rstn_i || softrst_i) begin
         ev_q   <= '0;
         intr_q <= 1'b0;
      end else begin
         ev_q   <= ev_d;
         intr_q <= intr_d;
      end
   end

   // Out-of-range indices match no cell, so such writes fall away silently.
   for (genvar n = 0; n < N_COUNTERS; n++) begin : g_cell
      assign wr_sel[n] = wr_en_i && (wr_idx_i == IDX_W'(n));

      pmu_counter_cell #(
         .REG_WIDTH (REG_WIDTH)
      ) u_cell (
         .clk_i     (clk_i),
         .rstn_i    (rstn_i),
         .softrst_i (softrst_i),
         .inc_i     (ev_q[n]),
         .wr_i      (wr_sel[n]),
         .wr_data_i (wr_data_i),
         .ovf_clr_i (ovf_clr_i[n]),
         .value_o   (counter_value_o[n]),
         .ovf_o     (ovf[n])
      );
   end

   assign overflow_o      = ovf;
   assign intr_overflow_o = intr_q;

endmodule
